bus_arbiter_rr: RTL

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

---
 rtl/bus_pkg.sv | 17 +
 rtl/arb_pick.sv | 44 ++++
 rtl/bus_arbiter_rr.sv | 119 +++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared FSM state, priority-mode encodings and defaults for the bus arbiter
package bus_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;

  localparam int DEF_NUM_MASTERS = 4;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_MAX_BURST   = 8;
  localparam int DEF_PRIO_MODE   = 0;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner selection: first requester at/above a start index
// rtl/arb_pick.sv - (start is rr_ptr in round-robin mode, 0 in fixed-priority mode)
module arb_pick
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       rr_ptr,
  input  logic                   mode,
  output logic [IDX_W-1:0]       winner,
  output logic                   valid
);

  localparam logic [IDX_W:0] NM = (IDX_W+1)'(NUM_MASTERS);

  logic [IDX_W-1:0]         start;
  logic [2*NUM_MASTERS-1:0] dbl;
  logic [NUM_MASTERS-1:0]   rot;
  logic [IDX_W-1:0]         off;
  logic [IDX_W:0]           sum;

  assign dbl = {req, req};

  // Rotate so the start index sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    start = (mode == PRIO_FIXED) ? '0 : rr_ptr;
    rot   = dbl[start +: NUM_MASTERS];
    off   = '0;
    valid = |req;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IDX_W'(i);
      end
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= NM) begin
      sum = sum - NM;
    end
    winner = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - burst-based bus arbiter with round-robin or fixed priority,
// rtl/bus_arbiter_rr.sv - one IDLE arbitration cycle between ownerships
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MAX_BURST   = DEF_MAX_BURST,
  parameter int PRIO_MODE   = DEF_PRIO_MODE
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic [NUM_MASTERS*DATA_W-1:0]  req_data,
  input  logic [NUM_MASTERS-1:0]         req_last,
  input  logic                           bus_ready,
  output logic [DATA_W-1:0]              bus_data,
  output logic                           bus_valid,
  output logic [NUM_MASTERS-1:0]         grant,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
  output logic                           busy
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int BC_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_MASTERS - 1);
  localparam logic             MODE      = (PRIO_MODE == 1) ? PRIO_FIXED : PRIO_RR;
  localparam logic [NUM_MASTERS-1:0] ONE = NUM_MASTERS'(1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_d;
  logic [IDX_W-1:0]       gid_d;
  logic [IDX_W-1:0]       rr_ptr, rr_ptr_d;
  logic [BC_W-1:0]        beat_cnt, beat_cnt_d;

  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   owner_req;
  logic                   xfer;
  logic                   release_now;

  logic [DATA_W-1:0]      data_arr [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  arb_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .mode   (MODE),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  // Bus outputs are decoded from the registered state, so reset zeroes them asynchronously.
  assign busy      = (state_q == ST_OWN);
  assign owner_req = req[grant_id];
  assign bus_valid = busy && owner_req;
  assign bus_data  = busy ? data_arr[grant_id] : '0;
  assign xfer      = bus_valid && bus_ready;

  assign release_now = busy &&
                       (!owner_req || (xfer && (req_last[grant_id] || beat_cnt == LAST_BEAT)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant    <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state_q  <= state_d;
      grant    <= grant_d;
      grant_id <= gid_d;
      rr_ptr   <= rr_ptr_d;
      beat_cnt <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant;
    gid_d      = grant_id;
    rr_ptr_d   = rr_ptr;
    beat_cnt_d = beat_cnt;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          state_d = ST_OWN;
          grant_d = ONE << pick_idx;
          gid_d   = pick_idx;
        end
      end
      ST_OWN: begin
        if (release_now) begin
          state_d    = ST_IDLE;
          grant_d    = '0;
          beat_cnt_d = '0;
          rr_ptr_d   = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

endmodule
